// File: rtl/param_seq_divider_if.sv
// Handshake bus for param_seq_divider: operand channel in, result channel out.
interface param_seq_divider_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 ovf;
    logic                 dbz;

    // Producer of operands / consumer of results
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, ovf, dbz
    );

    // The divider itself
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, ovf, dbz
    );
endinterface

// File: rtl/param_seq_divider.sv
// Sequential unsigned restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, with overflow and divide-by-zero short-cuts.
module param_seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    param_seq_divider_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;

    logic [WIDTH-1:0]   d;          // captured divisor
    logic [WIDTH-1:0]   r;          // partial remainder
    logic [WIDTH-1:0]   q;          // shifting dividend low half / quotient bits
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   q_out;
    logic [WIDTH-1:0]   r_out;
    logic               ovf_out;
    logic               dbz_out;

    logic               in_ready_c;
    logic               out_valid_c;
    logic               accept;
    logic               exc_dbz;
    logic               exc_ovf;
    logic               last_iter;

    logic [WIDTH:0]     t;
    logic [WIDTH:0]     t_sub;
    logic               ge;
    logic [WIDTH-1:0]   r_step;
    logic [WIDTH-1:0]   q_step;

    // One restoring step: shift in next dividend bit, subtract divisor if it fits
    always_comb begin
        t      = {r, q[WIDTH-1]};
        t_sub  = t - {1'b0, d};
        ge     = (t >= {1'b0, d});
        r_step = ge ? t_sub[WIDTH-1:0] : t[WIDTH-1:0];
        q_step = {q[WIDTH-2:0], ge};
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nx    = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        accept      = 1'b0;
        exc_dbz     = (bus.divisor == '0);
        exc_ovf     = (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);
        last_iter   = (cnt == CW'(WIDTH - 1));
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept   = 1'b1;
                    state_nx = (exc_dbz || exc_ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operand capture, iteration and result registers; results only change
    // when a new result is produced so they stay put through DONE and IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            d       <= '0;
            r       <= '0;
            q       <= '0;
            cnt     <= '0;
            q_out   <= '0;
            r_out   <= '0;
            ovf_out <= 1'b0;
            dbz_out <= 1'b0;
        end else if (accept) begin
            d   <= bus.divisor;
            r   <= bus.dividend[2*WIDTH-1:WIDTH];
            q   <= bus.dividend[WIDTH-1:0];
            cnt <= '0;
            if (exc_dbz) begin
                q_out   <= '1;
                r_out   <= bus.dividend[WIDTH-1:0];
                ovf_out <= 1'b0;
                dbz_out <= 1'b1;
            end else if (exc_ovf) begin
                q_out   <= '1;
                r_out   <= '0;
                ovf_out <= 1'b1;
                dbz_out <= 1'b0;
            end
        end else if (state == CALC) begin
            r   <= r_step;
            q   <= q_step;
            cnt <= cnt + CW'(1);
            if (last_iter) begin
                q_out   <= q_step;
                r_out   <= r_step;
                ovf_out <= 1'b0;
                dbz_out <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.quotient  = q_out;
    assign bus.remainder = r_out;
    assign bus.ovf       = ovf_out;
    assign bus.dbz       = dbz_out;
endmodule

// File: tb/tb_param_seq_divider.sv
// Bench for param_seq_divider (WIDTH=8): vector table, hold/reset sequences,
// then random operands with random result backpressure through a scoreboard.
module tb_param_seq_divider;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    param_seq_divider_if #(.WIDTH(W)) bus();

    param_seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        ovf;
        logic        dbz;
    } res_t;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        ovf;
        logic        dbz;
        int          lat;
    } vec_t;

    res_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    bit   rnd_bp = 1'b0;
    logic or_force = 1'b0;

    // Cycle counter
    always @(posedge clk) cycle <= cycle + 1;

    // Result-channel backpressure driver, updated just after each edge
    always @(posedge clk) begin
        #1;
        bus.out_ready = rnd_bp ? 1'($urandom_range(0, 1)) : or_force;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic res_t model(input logic [15:0] dvd, input logic [7:0] dvs);
        res_t e;
        e.dvd = dvd;
        e.dvs = dvs;
        if (dvs == 8'd0) begin
            e.q = 8'hFF; e.r = dvd[7:0]; e.ovf = 1'b0; e.dbz = 1'b1;
        end else if (dvd[15:8] >= dvs) begin
            e.q = 8'hFF; e.r = 8'h00; e.ovf = 1'b1; e.dbz = 1'b0;
        end else begin
            e.q = 8'(dvd / {8'd0, dvs});
            e.r = 8'(dvd % {8'd0, dvs});
            e.ovf = 1'b0; e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard monitor: a result is consumed on any edge with valid && ready
    res_t m;
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got q=%0d r=%0d with empty scoreboard", bus.quotient, bus.remainder);
            end else begin
                m = sb.pop_front();
                chk("quotient", 32'(bus.quotient), 32'(m.q));
                chk("remainder", 32'(bus.remainder), 32'(m.r));
                chk("ovf", 32'(bus.ovf), 32'(m.ovf));
                chk("dbz", 32'(bus.dbz), 32'(m.dbz));
                if (!m.ovf && !m.dbz) begin
                    chk("identity", 32'(bus.quotient) * 32'(m.dvs) + 32'(bus.remainder), 32'(m.dvd));
                    chk("rem_lt_div", 32'(bus.remainder < m.dvs), 32'd1);
                end
            end
        end
    end

    task automatic send(input logic [15:0] dvd, input logic [7:0] dvs, input res_t e, output int acc);
        @(posedge clk);
        #1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc = cycle;
                bus.in_valid = 1'b0;
                sb.push_back(e);
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL accept_timeout: got no in_ready expected in_ready=1");
        bus.in_valid = 1'b0;
        acc = -1;
    endtask

    task automatic wait_valid(input int acc, output int lat);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                lat = cycle - acc;
                return;
            end
        end
        lat = -1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) return;
        end
        tests++;
        fails++;
        $display("FAIL idle_timeout: got in_ready=0 expected in_ready=1");
    endtask

    vec_t vt[10];
    res_t e;
    int   acc;
    int   lat;
    logic [7:0] dvs;
    logic [7:0] hi;
    int   mode;

    initial begin
        vt[0] = '{16'd1000,  8'd7,   8'd142,  8'd6,    1'b0, 1'b0, 8};
        vt[1] = '{16'hFE01,  8'hFF,  8'hFF,   8'h00,   1'b0, 1'b0, 8};
        vt[2] = '{16'hFFFF,  8'hFF,  8'hFF,   8'h00,   1'b1, 1'b0, 0};
        vt[3] = '{16'h04D2,  8'h00,  8'hFF,   8'hD2,   1'b0, 1'b1, 0};
        vt[4] = '{16'd100,   8'd9,   8'd11,   8'd1,    1'b0, 1'b0, 8};
        vt[5] = '{16'd0,     8'd5,   8'd0,    8'd0,    1'b0, 1'b0, 8};
        vt[6] = '{16'hFFFF,  8'h00,  8'hFF,   8'hFF,   1'b0, 1'b1, 0};
        vt[7] = '{16'h7FFF,  8'h80,  8'hFF,   8'h7F,   1'b0, 1'b0, 8};
        vt[8] = '{16'h0100,  8'h01,  8'hFF,   8'h00,   1'b1, 1'b0, 0};
        vt[9] = '{16'h00FF,  8'h01,  8'hFF,   8'h00,   1'b0, 1'b0, 8};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        bus.out_ready = 1'b0;
        or_force     = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_quotient", 32'(bus.quotient), 32'd0);
        chk("rst_remainder", 32'(bus.remainder), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_dbz", 32'(bus.dbz), 32'd0);

        // Vector table with latency check; values checked by the monitor
        for (int i = 0; i < 10; i++) begin
            e = '{vt[i].dvd, vt[i].dvs, vt[i].q, vt[i].r, vt[i].ovf, vt[i].dbz};
            send(vt[i].dvd, vt[i].dvs, e, acc);
            wait_valid(acc, lat);
            chk($sformatf("latency_vec%0d", i), 32'(lat), 32'(vt[i].lat));
            wait_idle();
        end

        // Backpressure: result held for 5 cycles with out_ready low
        @(negedge clk);
        or_force = 1'b0;
        e = model(16'd1000, 8'd7);
        send(16'd1000, 8'd7, e, acc);
        wait_valid(acc, lat);
        chk("hold_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_quotient", 32'(bus.quotient), 32'd142);
            chk("hold_remainder", 32'(bus.remainder), 32'd6);
        end
        @(negedge clk);
        or_force = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("release_keep_q", 32'(bus.quotient), 32'd142);

        // Reset during the third CALC cycle discards the operation
        e = model(16'd5000, 8'd77);
        send(16'd5000, 8'd77, e, acc);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_quotient", 32'(bus.quotient), 32'd0);
        chk("midrst_remainder", 32'(bus.remainder), 32'd0);
        chk("midrst_ovf", 32'(bus.ovf), 32'd0);
        chk("midrst_dbz", 32'(bus.dbz), 32'd0);
        e = '{16'd100, 8'd9, 8'd11, 8'd1, 1'b0, 1'b0};
        send(16'd100, 8'd9, e, acc);
        wait_valid(acc, lat);
        chk("postrst_latency", 32'(lat), 32'd8);
        wait_idle();

        // Random operands through the scoreboard with random backpressure
        rnd_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 3));
            if (mode == 0) begin
                dvs = 8'd0;
                hi  = 8'($urandom_range(0, 255));
            end else if (mode == 1) begin
                dvs = 8'($urandom_range(1, 255));
                hi  = 8'($urandom_range(int'(dvs), 255));
            end else begin
                dvs = 8'($urandom_range(1, 255));
                hi  = 8'($urandom_range(0, int'(dvs) - 1));
            end
            e = model({hi, 8'($urandom_range(0, 255))}, dvs);
            send(e.dvd, e.dvs, e, acc);
        end
        rnd_bp = 1'b0;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
